// File: rtl/flag_unit_if.sv
// EX-stage result bus, ID-stage branch query and condition-code outputs for flag_unit.
interface flag_unit_if #(parameter int WIDTH = 16);
  logic             ex_valid;
  logic [3:0]       ex_opcode;
  logic [WIDTH-1:0] alu_result;
  logic             alu_ovfl;
  logic             stall;
  logic             flush;
  logic             br_req;
  logic [2:0]       br_ccc;
  logic             flag_z;
  logic             flag_v;
  logic             flag_n;
  logic             br_taken;
  logic             halted;

  modport master (
    output ex_valid, ex_opcode, alu_result, alu_ovfl, stall, flush, br_req, br_ccc,
    input  flag_z, flag_v, flag_n, br_taken, halted
  );

  modport slave (
    input  ex_valid, ex_opcode, alu_result, alu_ovfl, stall, flush, br_req, br_ccc,
    output flag_z, flag_v, flag_n, br_taken, halted
  );
endinterface

// File: rtl/flag_unit.sv
// Condition-code register behind the EX ALU plus branch-condition evaluation
// for ID, with optional same-cycle bypass of the flags being committed.
module flag_unit #(
  parameter int WIDTH  = 16,
  parameter int BYPASS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  flag_unit_if.slave fu
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic z_q, v_q, n_q, halted_q;
  logic z_d, v_d, n_d, halted_d;
  logic commit;
  logic wr_all, wr_z, is_hlt;
  logic ez, ev, en;
  logic cond;

  always_comb begin
    wr_all = 1'b0;
    wr_z   = 1'b0;
    is_hlt = 1'b0;
    case (fu.ex_opcode)
      OP_ADD, OP_SUB:                 wr_all = 1'b1;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: wr_z   = 1'b1;
      OP_HLT:                         is_hlt = 1'b1;
      default: ;
    endcase
  end

  // flush dominates stall; a halted core never commits again
  assign commit = fu.ex_valid & ~fu.stall & ~fu.flush & ~halted_q;

  always_comb begin
    z_d      = z_q;
    v_d      = v_q;
    n_d      = n_q;
    halted_d = halted_q;
    if (commit) begin
      if (wr_all | wr_z) z_d = (fu.alu_result == '0);
      if (wr_all) begin
        v_d = fu.alu_ovfl;
        n_d = fu.alu_result[WIDTH-1];
      end
      if (is_hlt) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      n_q      <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      z_q      <= z_d;
      v_q      <= v_d;
      n_q      <= n_d;
      halted_q <= halted_d;
    end
  end

  // *_d already equals the register when nothing commits, so it is the bypass value
  always_comb begin
    if (BYPASS != 0) begin
      ez = z_d;
      ev = v_d;
      en = n_d;
    end else begin
      ez = z_q;
      ev = v_q;
      en = n_q;
    end
  end

  always_comb begin
    cond = 1'b0;
    case (fu.br_ccc)
      3'b000: cond = ~ez;
      3'b001: cond = ez;
      3'b010: cond = ~ez & ~en;
      3'b011: cond = en;
      3'b100: cond = ez | ~en;
      3'b101: cond = en | ez;
      3'b110: cond = ev;
      3'b111: cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign fu.br_taken = fu.br_req & cond;
  assign fu.flag_z   = z_q;
  assign fu.flag_v   = v_q;
  assign fu.flag_n   = n_q;
  assign fu.halted   = halted_q;

endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit: bypassed and register-only instances driven in lockstep.
module tb_flag_unit;

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, XOR = 4'b0010, RED = 4'b0011;
  localparam logic [3:0] SLL = 4'b0100, SRA = 4'b0101, ROR = 4'b0110, PAD = 4'b0111;
  localparam logic [3:0] LW  = 4'b1000, HLT = 4'b1111;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  flag_unit_if #(.WIDTH(16)) if_b ();
  flag_unit_if #(.WIDTH(16)) if_n ();

  flag_unit #(.WIDTH(16), .BYPASS(1)) u_byp (.clk(clk), .rst_n(rst_n), .fu(if_b));
  flag_unit #(.WIDTH(16), .BYPASS(0)) u_reg (.clk(clk), .rst_n(rst_n), .fu(if_n));

  typedef struct {
    string      tag;
    logic [3:0] exp;   // {z, v, n, halted}
  } sb_t;
  sb_t sb[$];

  int n_pass = 0;
  int n_total = 0;

  logic m_z = 1'b0, m_v = 1'b0, m_n = 1'b0, m_h = 1'b0;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // condition outcomes indexed by ccc
  function automatic logic cond_f(input logic [2:0] c, input logic z, input logic v, input logic n);
    logic [7:0] tbl;
    tbl = {1'b1, v, n | z, z | ~n, n, ~z & ~n, z, ~z};
    return tbl[c];
  endfunction

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                       input logic ov, input logic st, input logic fl,
                       input logic br, input logic [2:0] ccc);
    if_b.ex_valid = v;  if_n.ex_valid = v;
    if_b.ex_opcode = op; if_n.ex_opcode = op;
    if_b.alu_result = res; if_n.alu_result = res;
    if_b.alu_ovfl = ov; if_n.alu_ovfl = ov;
    if_b.stall = st;    if_n.stall = st;
    if_b.flush = fl;    if_n.flush = fl;
    if_b.br_req = br;   if_n.br_req = br;
    if_b.br_ccc = ccc;  if_n.br_ccc = ccc;
  endtask

  task automatic step(input string tag, input logic v, input logic [3:0] op,
                      input logic [15:0] res, input logic ov, input logic st,
                      input logic fl, input logic br, input logic [2:0] ccc);
    logic nz, nv, nn, nh, com;
    sb_t e;
    drive(v, op, res, ov, st, fl, br, ccc);
    nz = m_z; nv = m_v; nn = m_n; nh = m_h;
    com = v & ~st & ~fl & ~m_h;
    if (com) begin
      if (op == ADD || op == SUB) begin
        nz = (res == 16'h0000); nv = ov; nn = res[15];
      end else if (op == XOR || op == SLL || op == SRA || op == ROR) begin
        nz = (res == 16'h0000);
      end else if (op == HLT) begin
        nh = 1'b1;
      end
    end
    #1;
    chk({tag, "/br_byp"}, {3'b0, if_b.br_taken}, {3'b0, br & cond_f(ccc, nz, nv, nn)});
    chk({tag, "/br_reg"}, {3'b0, if_n.br_taken}, {3'b0, br & cond_f(ccc, m_z, m_v, m_n)});
    sb.push_back('{tag, {nz, nv, nn, nh}});
    m_z = nz; m_v = nv; m_n = nn; m_h = nh;
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk({tag, "/sb_empty"}, 4'h1, 4'h0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "/flags_byp"}, {if_b.flag_z, if_b.flag_v, if_b.flag_n, if_b.halted}, e.exp);
      chk({e.tag, "/flags_reg"}, {if_n.flag_z, if_n.flag_v, if_n.flag_n, if_n.halted}, e.exp);
    end
  endtask

  // asynchronous reset asserted mid-cycle, checked before any clock edge
  task automatic mid_reset(input string tag);
    drive(1'b0, ADD, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001);
    #3 rst_n = 1'b0;
    #1;
    chk({tag, "/flags_byp"}, {if_b.flag_z, if_b.flag_v, if_b.flag_n, if_b.halted}, 4'h0);
    chk({tag, "/flags_reg"}, {if_n.flag_z, if_n.flag_v, if_n.flag_n, if_n.halted}, 4'h0);
    chk({tag, "/eq_byp"}, {3'b0, if_b.br_taken}, 4'h0);
    chk({tag, "/eq_reg"}, {3'b0, if_n.br_taken}, 4'h0);
    if_b.br_ccc = 3'b111; if_n.br_ccc = 3'b111;
    #1;
    chk({tag, "/un_byp"}, {3'b0, if_b.br_taken}, 4'h1);
    chk({tag, "/un_reg"}, {3'b0, if_n.br_taken}, 4'h1);
    m_z = 1'b0; m_v = 1'b0; m_n = 1'b0; m_h = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    drive(1'b0, ADD, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    #1;
    mid_reset("reset0");

    // basic writes and bypass
    step("add_zero",  1, ADD, 16'h0000, 0, 0, 0, 1, 3'b001);
    step("xor_8001",  1, XOR, 16'h8001, 0, 0, 0, 1, 3'b011);
    step("sub_ovfl",  1, SUB, 16'h8000, 1, 0, 0, 1, 3'b110);
    step("add_sat",   1, ADD, 16'h7FFF, 1, 0, 0, 1, 3'b010);

    // stall holds, then commits once released; flush beats stall
    for (int i = 0; i < 3; i++)
      step("stall_add", 1, ADD, 16'h0000, 0, 1, 0, 1, 3'b001);
    step("stall_rel", 1, ADD, 16'h0000, 0, 0, 0, 1, 3'b001);
    step("flush_stl", 1, SUB, 16'h8000, 1, 1, 1, 1, 3'b011);
    step("flush",     1, SUB, 16'h8000, 1, 0, 1, 1, 3'b110);
    step("bubble",    0, ADD, 16'h8000, 1, 0, 0, 1, 3'b110);

    // Z-only ops and non-flag ops
    step("xor_0001",  1, XOR, 16'h0001, 1, 0, 0, 1, 3'b001);
    step("red_zero",  1, RED, 16'h0000, 0, 0, 0, 1, 3'b001);
    step("pad_zero",  1, PAD, 16'h0000, 0, 0, 0, 1, 3'b001);
    step("lw_zero",   1, LW,  16'h0000, 1, 0, 0, 1, 3'b110);
    step("sll_zero",  1, SLL, 16'h0000, 1, 0, 0, 1, 3'b000);
    step("sra_ffff",  1, SRA, 16'hFFFF, 1, 0, 0, 1, 3'b101);
    step("ror_zero",  1, ROR, 16'h0000, 0, 0, 0, 1, 3'b100);
    step("sub_neg",   1, SUB, 16'h8000, 1, 0, 0, 1, 3'b100);

    // halt is sticky and freezes flags
    step("hlt",       1, HLT, 16'h0000, 0, 0, 0, 1, 3'b001);
    step("post_hlt",  1, ADD, 16'h0000, 0, 0, 0, 1, 3'b001);
    step("post_hlt2", 1, XOR, 16'h0000, 0, 0, 0, 1, 3'b000);
    for (int c = 0; c < 8; c++)
      step("ccc_table", 0, ADD, 16'h0000, 0, 0, 0, 1, c[2:0]);
    step("no_br_req", 1, ADD, 16'h0000, 0, 0, 0, 0, 3'b111);

    // reset clears halted; core commits again
    mid_reset("reset1");
    step("rst_add",   1, ADD, 16'hFFFE, 0, 0, 0, 1, 3'b011);
    step("rst_xor",   1, XOR, 16'h0000, 1, 0, 0, 1, 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
